// File: rtl/fmap_par2ser.sv
// Double-buffered parallel-to-serial output stage: accepts a DP-word column in one handshake and
// streams it out one word per cycle, lowest word first.
module fmap_par2ser #(
  parameter int unsigned DW = 32,
  parameter int unsigned DP = 56,
  parameter int unsigned CW = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DP*DW-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [DW-1:0]    data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [CW-1:0]    idx_o,
  output logic             last_o,
  output logic             busy_o
);

  logic [DW-1:0] bank_q [2][DP];

  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [CW-1:0] rd_idx_q, rd_idx_d;

  logic accept;
  logic pop;
  logic rls;

  // ready_o depends only on reset and fill level, never on valid_i, so no loop forms upstream.
  assign ready_o = !rst && (cnt_q < 2'd2);
  assign valid_o = (cnt_q != 2'd0);
  assign busy_o  = valid_o;
  assign last_o  = valid_o && (rd_idx_q == CW'(DP - 1));
  assign idx_o   = rd_idx_q;
  assign data_o  = valid_o ? bank_q[rd_ptr_q][rd_idx_q] : '0;

  assign accept = valid_i && ready_o;
  assign pop    = valid_o && ready_i;
  assign rls    = pop && last_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    rd_idx_d = rd_idx_q;

    if (accept) begin
      wr_ptr_d = ~wr_ptr_q;
    end

    if (pop) begin
      if (last_o) begin
        rd_idx_d = '0;
        rd_ptr_d = ~rd_ptr_q;
      end else begin
        rd_idx_d = rd_idx_q + 1'b1;
      end
    end

    // A fill and a release in the same cycle cancel out.
    if (accept && !rls) begin
      cnt_d = cnt_q + 2'd1;
    end else if (rls && !accept) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      rd_idx_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      rd_idx_q <= rd_idx_d;
    end
  end

  // Bank contents are left unreset; valid_o gates every read.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < int'(DP); k++) begin
        bank_q[wr_ptr_q][k] <= data_i[k*DW +: DW];
      end
    end
  end

endmodule
